// File: rtl/aes_pkg.sv
// Shared AES controller types: FSM states, round constants, block type.
// Imported by the round controller and any datapath wrappers.
package aes_pkg;

  localparam int NUM_ROUNDS_DEF = 10;
  localparam int ROUND_W        = 4;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer driving an external round datapath.
// Accept, iterate NUM_ROUNDS rounds, then hold ciphertext until taken.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  input  logic [127:0]       in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [ROUND_W-1:0] dp_round,
  output logic               dp_last,
  output logic [127:0]       dp_data,
  output logic [127:0]       dp_key,
  input  logic [127:0]       dp_res_data,
  input  logic [127:0]       dp_res_key,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_cnt
);

  aes_state_e         state_q;
  aes_state_e         state_d;
  block_t             state_reg;
  block_t             key_reg;
  logic [ROUND_W-1:0] round_cnt;
  logic               in_round;
  logic               last_rnd;

  assign in_round = (state_q == ST_ROUND);
  assign last_rnd = (round_cnt == ROUND_W'(NUM_ROUNDS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_ROUND;
      ST_ROUND: if (last_rnd)  state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // round_cnt parks at NUM_ROUNDS after the final round
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      key_reg   <= '0;
      round_cnt <= '0;
      blk_cnt   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_reg <= in_data ^ in_key;
            key_reg   <= in_key;
            round_cnt <= ROUND_W'(1);
          end
        end
        ST_ROUND: begin
          state_reg <= dp_res_data;
          key_reg   <= dp_res_key;
          if (!last_rnd) begin
            round_cnt <= round_cnt + ROUND_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = state_reg;
  assign dp_data   = state_reg;
  assign dp_key    = key_reg;
  assign dp_round  = in_round ? round_cnt : '0;
  assign dp_last   = in_round && last_rnd;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of cipher rounds (AES-128 only; other values unsupported).
REQ-002 Parameter CNT_W, default 16, width of the completed-block counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  plaintext/key offered.
REQ-006 in_ready  output  1  controller can accept a block.
REQ-007 in_data  input  128  plaintext block.
REQ-008 in_key  input  128  cipher key.
REQ-009 out_valid  output  1  ciphertext available.
REQ-010 out_ready  input  1  consumer accepts ciphertext.
REQ-011 out_data  output  128  ciphertext block.
REQ-012 dp_round  output  4  round number presented to the external round datapath.
REQ-013 dp_last  output  1  high selects the final-round path (no MixColumns).
REQ-014 dp_data  output  128  state presented to the datapath.
REQ-015 dp_key  output  128  previous round key presented to the datapath.
REQ-016 dp_res_data  input  128  combinational round result (round key already added).
REQ-017 dp_res_key  input  128  combinational round key generated for dp_round.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 blk_cnt  output  CNT_W  count of ciphertext blocks handed off.

Function
REQ-020 FSM states: IDLE, ROUND, DONE.
REQ-021 in_ready is high only in IDLE, and out_valid is high only in DONE.
REQ-022 IDLE with in_valid high: state_reg <= in_data ^ in_key, key_reg <= in_key, round_cnt <= 1, go to ROUND.
REQ-023 ROUND: dp_data = state_reg, dp_key = key_reg, dp_round = round_cnt, and dp_last = (round_cnt == NUM_ROUNDS).
REQ-024 Each ROUND cycle: state_reg <= dp_res_data, key_reg <= dp_res_key, round_cnt <= round_cnt + 1.
REQ-025 ROUND with round_cnt == NUM_ROUNDS: capture the result, go to DONE, and leave round_cnt at NUM_ROUNDS (no wrap).
REQ-026 Latency: a block accepted at edge T raises out_valid after edge T+NUM_ROUNDS, i.e. 10 ROUND cycles.
REQ-027 DONE: out_data = state_reg, held stable while out_valid is high and out_ready is low.
REQ-028 DONE with out_ready high: go to IDLE and increment blk_cnt, wrapping modulo 2^CNT_W.
REQ-029 Minimum issue interval is 12 cycles (accept, 10 rounds, handoff); no new block is accepted in DONE, even when out_ready is high.
REQ-030 in_valid is ignored outside IDLE; inputs change nothing in ROUND or DONE.
REQ-031 out_ready is ignored outside DONE.
REQ-032 Outside ROUND: dp_round = 0, dp_last = 0, and dp_data/dp_key show register contents.
REQ-033 Unreachable FSM encodings return to IDLE on the next edge.

Reset
REQ-034 On rst_n low, immediately: FSM = IDLE, round_cnt = 0, state_reg = 0, key_reg = 0, blk_cnt = 0.
REQ-035 During reset: in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
REQ-036 Reset asserted mid-ROUND or in DONE abandons the block; no output is produced for it after release.
REQ-037 After rst_n deasserts, the first edge with in_valid high accepts a block.

Structure
REQ-038 Shared package aes_pkg holds the FSM state enum, NUM_ROUNDS_DEF = 10, ROUND_W = 4 and the 128-bit block typedef.
REQ-039 The round datapath stays outside this block; no sub-module is instantiated inside aes_round_ctrl.
REQ-040 The bench wires dp_* to the existing key-generation/SubBytes/ShiftRows/MixColumns path, selecting the final-round path on dp_last.

Verification
REQ-041 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a at T+10, blk_cnt 1.
REQ-042 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32.
REQ-043 Hold out_ready low 5 cycles in DONE -> out_data stable, in_ready 0; a new in_valid pulse during that window is dropped.
REQ-044 Assert rst_n low at round 5 -> out_valid never rises for that block; the next vector still yields the correct ciphertext.
REQ-045 Back-to-back vectors with in_valid held high -> accepts 12 cycles apart, dp_last high exactly once per block, at dp_round 10.
REQ-046 Preload CNT_W = 4, complete 16 blocks -> blk_cnt wraps to 0.
